// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the ID/EX hazard controller.
// Forwarding select codes, hazard FSM states, architectural x0.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN,
    MD_WAIT
  } state_e;

endpackage

// File: rtl/id_ex_hazard_ctrl_if.sv
// Pipeline-side bundle for the ID/EX hazard controller.
// master: pipeline registers; slave: the controller.
interface id_ex_hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs2;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_md_op;
  logic             branch_taken;
  logic [4:0]       mem_rd;
  logic             mem_reg_write;
  logic [4:0]       wb_rd;
  logic             wb_reg_write;
  logic             md_done;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_flush;
  logic             exmem_bubble;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             md_start;
  logic             md_error;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2,
    output ex_rs1, ex_rs2, ex_rd,
    output ex_mem_read, ex_md_op, branch_taken,
    output mem_rd, mem_reg_write,
    output wb_rd, wb_reg_write, md_done,
    input  pc_write, ifid_write, ifid_flush,
    input  idex_write, idex_flush, exmem_bubble,
    input  forward_a, forward_b,
    input  md_start, md_error, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2,
    input  ex_rs1, ex_rs2, ex_rd,
    input  ex_mem_read, ex_md_op, branch_taken,
    input  mem_rd, mem_reg_write,
    input  wb_rd, wb_reg_write, md_done,
    output pc_write, ifid_write, ifid_flush,
    output idex_write, idex_flush, exmem_bubble,
    output forward_a, forward_b,
    output md_start, md_error, stall_cnt
  );

endinterface

// File: rtl/id_ex_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding selects.
// EX/MEM result has priority over MEM/WB; x0 is never forwarded.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs1_i,
  input  logic [4:0] ex_rs2_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_reg_write_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_reg_write_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  function automatic logic [1:0] sel(
    input logic [4:0] rs,
    input logic [4:0] mrd,
    input logic       mwe,
    input logic [4:0] wrd,
    input logic       wwe
  );
    if (mwe && mrd != REG_ZERO && mrd == rs)
      return FWD_MEM;
    else if (wwe && wrd != REG_ZERO && wrd == rs)
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

  // Independent select per ALU operand
  always_comb begin
    fwd_a_o = sel(ex_rs1_i, mem_rd_i, mem_reg_write_i,
                  wb_rd_i, wb_reg_write_i);
    fwd_b_o = sel(ex_rs2_i, mem_rd_i, mem_reg_write_i,
                  wb_rd_i, wb_reg_write_i);
  end

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// Hazard/stall/flush control driven by the ID/EX register.
// Also sequences the multi-cycle MUL/DIV unit with a timeout.
module id_ex_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  id_ex_hazard_ctrl_if.slave  bus
);

  localparam int TW = $clog2(MD_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(MD_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             err_q, err_d;
  logic             ret_q, ret_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic pc_w, ifid_w, ifid_f;
  logic idex_w, idex_f, ex_bub, md_go;
  logic load_use;

  fwd_unit u_fwd (
    .ex_rs1_i        (bus.ex_rs1),
    .ex_rs2_i        (bus.ex_rs2),
    .mem_rd_i        (bus.mem_rd),
    .mem_reg_write_i (bus.mem_reg_write),
    .wb_rd_i         (bus.wb_rd),
    .wb_reg_write_i  (bus.wb_reg_write),
    .fwd_a_o         (bus.forward_a),
    .fwd_b_o         (bus.forward_b)
  );

  assign load_use = bus.ex_mem_read
                 && bus.ex_rd != REG_ZERO
                 && (bus.ex_rd == bus.id_rs1
                 || (bus.id_uses_rs2
                 && bus.ex_rd == bus.id_rs2));

  // Next state and pipeline controls; reset forces RUN defaults
  always_comb begin
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    ifid_f  = 1'b0;
    idex_w  = 1'b1;
    idex_f  = 1'b0;
    ex_bub  = 1'b0;
    md_go   = 1'b0;
    state_d = state_q;
    timer_d = timer_q;
    err_d   = err_q;
    ret_d   = 1'b0;
    if (!reset) begin
      unique case (state_q)
        RUN: begin
          if (bus.branch_taken) begin
            ifid_f = 1'b1;
            idex_f = 1'b1;
          end else if (bus.ex_md_op && !ret_q) begin
            // ret_q masks the finished op still held in ID/EX
            md_go   = 1'b1;
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_w  = 1'b0;
            ex_bub  = 1'b1;
            state_d = MD_WAIT;
            timer_d = '0;
          end else if (load_use) begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            idex_f = 1'b1;
          end
        end
        MD_WAIT: begin
          pc_w    = 1'b0;
          ifid_w  = 1'b0;
          idex_w  = 1'b0;
          ex_bub  = 1'b1;
          timer_d = timer_q + 1'b1;
          if (bus.md_done) begin
            state_d = RUN;
            ret_d   = 1'b1;
          end else if (timer_q == T_LAST) begin
            err_d   = 1'b1;
            state_d = RUN;
            ret_d   = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Saturating count of cycles with the PC held
  always_comb begin
    stall_d = stall_q;
    if (!pc_w && stall_q != '1)
      stall_d = stall_q + 1'b1;
  end

  // State, timer, sticky error and stall counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      timer_q <= '0;
      err_q   <= 1'b0;
      ret_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      ret_q   <= ret_d;
      stall_q <= stall_d;
    end
  end

  assign bus.pc_write     = pc_w;
  assign bus.ifid_write   = ifid_w;
  assign bus.ifid_flush   = ifid_f;
  assign bus.idex_write   = idex_w;
  assign bus.idex_flush   = idex_f;
  assign bus.exmem_bubble = ex_bub;
  assign bus.md_start     = md_go;
  assign bus.md_error     = err_q;
  assign bus.stall_cnt    = stall_q;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Bench for id_ex_hazard_ctrl: vector table plus MUL/DIV,
// timeout and asynchronous reset sequences.
module tb_id_ex_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  id_ex_hazard_ctrl_if #(.CNT_W(32)) bus ();

  id_ex_hazard_ctrl #(
    .MD_TIMEOUT (8),
    .CNT_W      (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_md_op;
    logic       branch_taken;
    logic [4:0] mem_rd;
    logic       mem_reg_write;
    logic [4:0] wb_rd;
    logic       wb_reg_write;
    logic       md_done;
  } in_t;

  typedef struct packed {
    logic [5:0]  ctl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        mds;
    logic        err;
    logic [31:0] stall;
  } obs_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [5:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       mds;
  } vec_t;

  // ctl = {pc_write, ifid_write, ifid_flush,
  //        idex_write, idex_flush, exmem_bubble}
  localparam logic [5:0] DEF = 6'b110100;
  localparam logic [5:0] LU  = 6'b000110;
  localparam logic [5:0] BR  = 6'b111110;
  localparam logic [5:0] MDW = 6'b000001;

  vec_t        tbl [14];
  obs_t        sbq [$];
  string       nmq [$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_stall = '0;
  logic        exp_err = 1'b0;

  function automatic in_t mk(
    int rs1, int rs2, int u2, int ers1, int ers2,
    int erd, int mr, int md, int br, int mrd,
    int mrw, int wrd, int wrw, int dn
  );
    in_t x;
    x.id_rs1        = 5'(rs1);
    x.id_rs2        = 5'(rs2);
    x.id_uses_rs2   = 1'(u2);
    x.ex_rs1        = 5'(ers1);
    x.ex_rs2        = 5'(ers2);
    x.ex_rd         = 5'(erd);
    x.ex_mem_read   = 1'(mr);
    x.ex_md_op      = 1'(md);
    x.branch_taken  = 1'(br);
    x.mem_rd        = 5'(mrd);
    x.mem_reg_write = 1'(mrw);
    x.wb_rd         = 5'(wrd);
    x.wb_reg_write  = 1'(wrw);
    x.md_done       = 1'(dn);
    return x;
  endfunction

  task automatic drive(input in_t x);
    bus.id_rs1        = x.id_rs1;
    bus.id_rs2        = x.id_rs2;
    bus.id_uses_rs2   = x.id_uses_rs2;
    bus.ex_rs1        = x.ex_rs1;
    bus.ex_rs2        = x.ex_rs2;
    bus.ex_rd         = x.ex_rd;
    bus.ex_mem_read   = x.ex_mem_read;
    bus.ex_md_op      = x.ex_md_op;
    bus.branch_taken  = x.branch_taken;
    bus.mem_rd        = x.mem_rd;
    bus.mem_reg_write = x.mem_reg_write;
    bus.wb_rd         = x.wb_rd;
    bus.wb_reg_write  = x.wb_reg_write;
    bus.md_done       = x.md_done;
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.ctl   = {bus.pc_write, bus.ifid_write,
               bus.ifid_flush, bus.idex_write,
               bus.idex_flush, bus.exmem_bubble};
    o.fa    = bus.forward_a;
    o.fb    = bus.forward_b;
    o.mds   = bus.md_start;
    o.err   = bus.md_error;
    o.stall = bus.stall_cnt;
    return o;
  endfunction

  task automatic expect_now(
    input string      nm,
    input logic [5:0] ctl,
    input logic [1:0] fa,
    input logic [1:0] fb,
    input logic       mds
  );
    obs_t  e, a;
    string n;
    e.ctl   = ctl;
    e.fa    = fa;
    e.fb    = fb;
    e.mds   = mds;
    e.err   = exp_err;
    e.stall = exp_stall;
    sbq.push_back(e);
    nmq.push_back(nm);
    #1;
    a = observe();
    e = sbq.pop_front();
    n = nmq.pop_front();
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got ctl=%b fa=%b fb=%b st=%b er=%b cnt=%0d, want ctl=%b fa=%b fb=%b st=%b er=%b cnt=%0d",
               n, a.ctl, a.fa, a.fb, a.mds, a.err, a.stall,
               e.ctl, e.fa, e.fb, e.mds, e.err, e.stall);
    end
    if (!ctl[5] && exp_stall != '1)
      exp_stall++;
  endtask

  task automatic step(
    input string      nm,
    input in_t        x,
    input logic [5:0] ctl,
    input logic [1:0] fa,
    input logic [1:0] fb,
    input logic       mds
  );
    @(negedge clk);
    drive(x);
    expect_now(nm, ctl, fa, fb, mds);
  endtask

  in_t z, m, t;

  initial begin
    z = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    m = z;
    m.ex_md_op = 1'b1;

    tbl[0]  = '{"idle",
      z, DEF, 2'b00, 2'b00, 1'b0};
    tbl[1]  = '{"fwd_mem_a",
      mk(0,0,0,5,0,0,0,0,0,5,1,5,1,0),
      DEF, 2'b10, 2'b00, 1'b0};
    tbl[2]  = '{"fwd_wb_a",
      mk(0,0,0,5,0,0,0,0,0,5,0,5,1,0),
      DEF, 2'b01, 2'b00, 1'b0};
    tbl[3]  = '{"fwd_mem_ab",
      mk(0,0,0,7,7,0,0,0,0,7,1,7,1,0),
      DEF, 2'b10, 2'b10, 1'b0};
    tbl[4]  = '{"fwd_x0",
      mk(0,0,0,0,0,0,0,0,0,0,1,0,1,0),
      DEF, 2'b00, 2'b00, 1'b0};
    tbl[5]  = '{"fwd_mix",
      mk(0,0,0,9,4,0,0,0,0,4,1,9,1,0),
      DEF, 2'b01, 2'b10, 1'b0};
    tbl[6]  = '{"lu_rs2",
      mk(1,3,1,0,0,3,1,0,0,0,0,0,0,0),
      LU, 2'b00, 2'b00, 1'b0};
    tbl[7]  = '{"lu_rd_x0",
      mk(1,0,1,0,0,0,1,0,0,0,0,0,0,0),
      DEF, 2'b00, 2'b00, 1'b0};
    tbl[8]  = '{"lu_no_rs2",
      mk(1,3,0,0,0,3,1,0,0,0,0,0,0,0),
      DEF, 2'b00, 2'b00, 1'b0};
    tbl[9]  = '{"lu_rs1",
      mk(3,0,0,0,0,3,1,0,0,0,0,0,0,0),
      LU, 2'b00, 2'b00, 1'b0};
    tbl[10] = '{"no_lu_alu",
      mk(3,0,0,0,0,3,0,0,0,0,0,0,0,0),
      DEF, 2'b00, 2'b00, 1'b0};
    tbl[11] = '{"br_over_lu",
      mk(1,3,1,0,0,3,1,0,1,0,0,0,0,0),
      BR, 2'b00, 2'b00, 1'b0};
    tbl[12] = '{"done_in_run",
      mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1),
      DEF, 2'b00, 2'b00, 1'b0};
    tbl[13] = '{"br_over_md",
      mk(0,0,0,0,0,0,0,1,1,0,0,0,0,0),
      BR, 2'b00, 2'b00, 1'b0};

    drive(z);
    @(negedge clk);
    expect_now("reset", DEF, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      step(tbl[i].name, tbl[i].in, tbl[i].ctl,
           tbl[i].fa, tbl[i].fb, tbl[i].mds);

    step("md_start", m, MDW, 2'b00, 2'b00, 1'b1);
    step("md_wait1", m, MDW, 2'b00, 2'b00, 1'b0);
    t = m;
    t.branch_taken = 1'b1;
    step("md_wait_br", t, MDW, 2'b00, 2'b00, 1'b0);
    step("md_wait3", m, MDW, 2'b00, 2'b00, 1'b0);
    t = m;
    t.md_done = 1'b1;
    step("md_done", t, MDW, 2'b00, 2'b00, 1'b0);
    step("md_run", z, DEF, 2'b00, 2'b00, 1'b0);

    step("to_start", m, MDW, 2'b00, 2'b00, 1'b1);
    for (int k = 0; k < 8; k++)
      step("to_wait", z, MDW, 2'b00, 2'b00, 1'b0);
    exp_err = 1'b1;
    step("to_run", z, DEF, 2'b00, 2'b00, 1'b0);
    t = z;
    t.md_done = 1'b1;
    step("to_late_done", t, DEF, 2'b00, 2'b00, 1'b0);
    step("to_sticky", z, DEF, 2'b00, 2'b00, 1'b0);

    step("rs_start", m, MDW, 2'b00, 2'b00, 1'b1);
    step("rs_wait", z, MDW, 2'b00, 2'b00, 1'b0);
    #2;
    reset = 1'b1;
    exp_stall = '0;
    exp_err = 1'b0;
    expect_now("rs_async", DEF, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step("rs_after", z, DEF, 2'b00, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_ctrl.md
Name: id_ex_hazard_ctrl

Overview:
- Control-side consumer of the ID/EX pipeline register outputs in the RV32 5-stage pipeline.
- Generates write-enable, flush and bubble controls back into the PC, IF/ID, ID/EX and EX/MEM registers.
- Generates the EX-stage forwarding selects.
- Sequences a multi-cycle MUL/DIV unit through a start/done handshake, with a timeout.

Parameters:
MD_TIMEOUT, 64, max cycles in MD_WAIT before md_error is raised
CNT_W, 32, width of the stall performance counter

Ports:
clk  in  1  clock
reset  in  1  reset (see Behaviour)
id_rs1  in  5  rs1 of instruction in IF/ID
id_rs2  in  5  rs2 of instruction in IF/ID
id_uses_rs2  in  1  IF/ID instruction reads rs2
ex_rs1  in  5  rs1_out of ID/EX
ex_rs2  in  5  rs2_out of ID/EX
ex_rd  in  5  rd_out of ID/EX
ex_mem_read  in  1  MemRead_out of ID/EX
ex_md_op  in  1  ID/EX holds a MUL/DIV
branch_taken  in  1  EX resolved taken branch/jump
mem_rd  in  5  rd of EX/MEM
mem_reg_write  in  1  RegWrite of EX/MEM
wb_rd  in  5  rd of MEM/WB
wb_reg_write  in  1  RegWrite of MEM/WB
md_done  in  1  MUL/DIV result valid, 1-cycle pulse
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to NOP
idex_write  out  1  ID/EX load enable
idex_flush  out  1  ID/EX clear (bubble)
exmem_bubble  out  1  load zero controls into EX/MEM
forward_a  out  2  ALU operand A select: 00 reg, 10 EX/MEM, 01 MEM/WB
forward_b  out  2  same for operand B
md_start  out  1  1-cycle pulse starting MUL/DIV
md_error  out  1  sticky timeout flag
stall_cnt  out  CNT_W  cycles with pc_write=0

Behaviour:
- Reset and clock: reset is asynchronous, active-high; clock is clk.
- Reset values:
  - State = RUN.
  - stall_cnt=0, md_error=0, md_start=0.
  - Combinational outputs in RUN with no hazard: pc_write=1, ifid_write=1, idex_write=1, all flush/bubble=0, forward=00.
- Forwarding (combinational, every state):
  - forward_a=10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs1.
  - Else forward_a=01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs1.
  - Else forward_a=00. EX/MEM wins over MEM/WB. forward_b is identical using ex_rs2.
- Load-use hazard: ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || (id_uses_rs2 && ex_rd==id_rs2)).
- States: RUN, MD_WAIT.
- RUN, priority order:
  1. branch_taken: ifid_flush=1, idex_flush=1, pc_write=1. Any load-use/md condition is ignored this cycle; the flushed instructions are squashed.
  2. ex_md_op: md_start=1 for this cycle only. pc_write=ifid_write=idex_write=0, exmem_bubble=1. Next state MD_WAIT, timer cleared.
  3. Load-use: pc_write=0, ifid_write=0, idex_flush=1 (exactly one bubble). No state change; the hazard clears next cycle by construction.
  4. Otherwise: defaults.
- MD_WAIT:
  - Outputs: pc_write=ifid_write=idex_write=0, exmem_bubble=1. branch_taken is ignored, since EX holds the md op.
  - md_done=1 in the same cycle: outputs as MD_WAIT; next state RUN with exmem_bubble=0 from the next cycle.
  - Timer increments each MD_WAIT cycle. On reaching MD_TIMEOUT without md_done: md_error<=1 (sticky until reset), next state RUN.
  - md_done while in RUN is ignored.
- stall_cnt: increments each cycle pc_write==0; saturates at all-ones.
- Reset mid-MD_WAIT: immediate return to RUN; md_start not reissued.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - State enum {RUN, MD_WAIT}.
  - REG_ZERO=5'd0.
- One natural sub-module: fwd_unit (pure combinational forwarding selects), instantiated once.

Test Plan:
- Reset asserted mid-cycle with state MD_WAIT → outputs immediately return to RUN defaults, stall_cnt=0.
- Forwarding: mem_rd=5, mem_reg_write=1, wb_rd=5, wb_reg_write=1, ex_rs1=5, ex_rs2=0 → forward_a=10, forward_b=00. Then mem_reg_write=0 → forward_a=01.
- Load-use: ex_mem_read=1, ex_rd=3, id_rs2=3, id_uses_rs2=1 → one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cnt +1. Same stimulus with ex_rd=0 → no stall.
- Branch priority: branch_taken=1 together with the load-use condition → ifid_flush=idex_flush=1, pc_write=1, no stall count.
- MUL/DIV: ex_md_op=1 → md_start high exactly 1 cycle. md_done arrives 4 cycles later → pc_write low 5 cycles total, then RUN; stall_cnt=5.
- Timeout: MD_TIMEOUT=8, md_done never arrives → md_error=1 after 8 MD_WAIT cycles, returns to RUN; md_error stays 1 until reset.
